// File: rtl/serial_sub_nbit_with_overflow.sv
// -----------------------------------------------------------------------------
// serial_sub_nbit_with_overflow
//
// Bit-serial two's-complement subtractor computing diff = a - b - bin,
// LSB first, one bit per clock. A single full-subtractor cell is fed from two
// right-shifting operand registers and a registered borrow. The unsigned
// borrow-out and the signed overflow are reported using the MSB borrow chain:
// overflow = (borrow into MSB) ^ (borrow out of MSB).
//
// Ports
//   clk       in   1      rising-edge clock
//   rst       in   1      synchronous reset, active-high
//   start     in   1      request; accepted in IDLE or DONE only
//   a         in   WIDTH  minuend, sampled on the accepted start edge
//   b         in   WIDTH  subtrahend, sampled on the accepted start edge
//   bin       in   1      borrow-in, sampled on the accepted start edge
//   busy      out  1      high while the serial loop runs
//   done      out  1      one-cycle pulse, result valid
//   diff      out  WIDTH  registered result
//   bout      out  1      borrow out of the MSB (unsigned a < b + bin)
//   overflow  out  1      signed overflow
//
// Timing: start accepted in cycle T -> busy in T+1..T+WIDTH, done in
// T+WIDTH+1. diff/bout/overflow change only at capture and hold afterwards.
// -----------------------------------------------------------------------------
module serial_sub_nbit_with_overflow #(
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             overflow
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_ZERO = CW'(0);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Full-subtractor difference bit.
    function automatic logic fs_diff(input logic x, input logic y, input logic bi);
        return x ^ y ^ bi;
    endfunction

    // Full-subtractor borrow-out.
    function automatic logic fs_borrow(input logic x, input logic y, input logic bi);
        return (~x & y) | (~x & bi) | (y & bi);
    endfunction

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] sa_q, sa_d;
    logic [WIDTH-1:0] sb_q, sb_d;
    // Holds the WIDTH-1 result bits produced so far; the final bit is
    // merged in directly at capture, so a full-width work register is not needed.
    logic [WIDTH-2:0] sd_q, sd_d;
    logic             br_q, br_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bout_q, bout_d;
    logic             overflow_q, overflow_d;

    logic             d_bit;
    logic             br_nxt;
    logic [WIDTH-1:0] sd_ext;

    assign d_bit  = fs_diff(sa_q[0], sb_q[0], br_q);
    assign br_nxt = fs_borrow(sa_q[0], sb_q[0], br_q);
    // New bit enters at the MSB; the concatenation is the shifted work value.
    assign sd_ext = {d_bit, sd_q};

    // Next-state and datapath logic for the serial subtract loop.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        sa_d       = sa_q;
        sb_d       = sb_q;
        sd_d       = sd_q;
        br_d       = br_q;
        diff_d     = diff_q;
        bout_d     = bout_q;
        overflow_d = overflow_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_RUN;
                    cnt_d   = CNT_ZERO;
                    sa_d    = a;
                    sb_d    = b;
                    br_d    = bin;
                    sd_d    = {(WIDTH-1){1'b0}};
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                sa_d = {1'b0, sa_q[WIDTH-1:1]};
                sb_d = {1'b0, sb_q[WIDTH-1:1]};
                sd_d = sd_ext[WIDTH-1:1];
                br_d = br_nxt;
                if (cnt_q == CNT_LAST) begin
                    // br_q is the borrow into the MSB at this point.
                    state_d    = S_DONE;
                    diff_d     = sd_ext;
                    bout_d     = br_nxt;
                    overflow_d = br_q ^ br_nxt;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d == S_RUN);
        done_d = (state_d == S_DONE);
    end

    // State, datapath and registered outputs with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= CNT_ZERO;
            sa_q       <= {WIDTH{1'b0}};
            sb_q       <= {WIDTH{1'b0}};
            sd_q       <= {(WIDTH-1){1'b0}};
            br_q       <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            diff_q     <= {WIDTH{1'b0}};
            bout_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sa_q       <= sa_d;
            sb_q       <= sb_d;
            sd_q       <= sd_d;
            br_q       <= br_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            diff_q     <= diff_d;
            bout_q     <= bout_d;
            overflow_q <= overflow_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign diff     = diff_q;
    assign bout     = bout_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_serial_sub_nbit_with_overflow.sv
module tb_serial_sub_nbit_with_overflow;

    localparam int W = 6;

    logic         clk;
    logic         rst_i;
    logic         start_i;
    logic [W-1:0] a_i;
    logic [W-1:0] b_i;
    logic         bin_i;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         bout;
    logic         overflow;

    int n_pass  = 0;
    int n_total = 0;

    serial_sub_nbit_with_overflow #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst_i),
        .start    (start_i),
        .a        (a_i),
        .b        (b_i),
        .bin      (bin_i),
        .busy     (busy),
        .done     (done),
        .diff     (diff),
        .bout     (bout),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // ---------------- behavioural model ----------------
    // Arithmetic reference: plain integer subtraction.
    function automatic void ref_sub(input int a, input int b, input int bi,
                                    output logic [W-1:0] d, output logic bo, output logic ov);
        int r, sa, sb, sr;
        r  = a - b - bi;
        d  = W'(r & ((1 << W) - 1));
        bo = (a < b + bi);
        sa = (a >= (1 << (W-1))) ? a - (1 << W) : a;
        sb = (b >= (1 << (W-1))) ? b - (1 << W) : b;
        sr = sa - sb - bi;
        ov = (sr < -(1 << (W-1))) || (sr > (1 << (W-1)) - 1);
    endfunction

    int           rem = 0;
    logic         m_valid = 1'b0;
    logic         m_busy, m_done, m_bout, m_ovf;
    logic [W-1:0] m_diff;
    logic [W-1:0] p_diff;
    logic         p_bout, p_ovf;

    // Protocol model: an accepted op takes W busy cycles, then one done cycle.
    always @(posedge clk) begin
        if (rst_i) begin
            rem     = 0;
            m_done  = 1'b0;
            m_diff  = '0;
            m_bout  = 1'b0;
            m_ovf   = 1'b0;
            m_valid = 1'b1;
        end else begin
            m_done = 1'b0;
            if (rem > 0) begin
                rem--;
                if (rem == 0) begin
                    m_done = 1'b1;
                    m_diff = p_diff;
                    m_bout = p_bout;
                    m_ovf  = p_ovf;
                end
            end else if (start_i) begin
                rem = W;
                ref_sub(int'(a_i), int'(b_i), int'(bin_i), p_diff, p_bout, p_ovf);
            end
        end
        m_busy = (rem > 0);
    end

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        if (m_valid) begin
            chk("busy",     32'(busy),     32'(m_busy));
            chk("done",     32'(done),     32'(m_done));
            chk("diff",     32'(diff),     32'(m_diff));
            chk("bout",     32'(bout),     32'(m_bout));
            chk("overflow", 32'(overflow), 32'(m_ovf));
        end
    end

    // ---------------- directed stimulus ----------------
    // Called at a negedge; returns at the negedge of the done cycle.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi,
                          input logic [W-1:0] ed, input logic eb, input logic eo,
                          input logic pulse);
        int n;
        a_i = a; b_i = b; bin_i = bi; start_i = 1'b1;
        @(negedge clk);
        n = 1;
        start_i = 1'b0;
        while (!done && n < 20) begin
            if (pulse && n == 3) begin
                start_i = 1'b1; a_i = 6'h3F; b_i = 6'h15; bin_i = 1'b1;
            end else begin
                start_i = 1'b0;
            end
            @(negedge clk);
            n++;
        end
        start_i = 1'b0;
        chk("done_latency", 32'(n), 32'd7);
        chk("lit_diff", 32'(diff), 32'(ed));
        chk("lit_bout", 32'(bout), 32'(eb));
        chk("lit_ovf",  32'(overflow), 32'(eo));
    endtask

    task automatic abort_op();
        int seen;
        a_i = 6'd9; b_i = 6'd2; bin_i = 1'b0; start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_i = 1'b1;
        @(negedge clk);
        rst_i = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_diff", 32'(diff), 32'd0);
        chk("abort_bout", 32'(bout), 32'd0);
        chk("abort_ovf",  32'(overflow), 32'd0);
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done) seen++;
        end
        chk("abort_no_done", 32'(seen), 32'd0);
    endtask

    initial begin
        rst_i = 1'b1; start_i = 1'b0; a_i = '0; b_i = '0; bin_i = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_i = 1'b0;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_diff", 32'(diff), 32'd0);
        chk("rst_bout", 32'(bout), 32'd0);
        chk("rst_ovf",  32'(overflow), 32'd0);
        @(negedge clk);

        run_op(6'd10, 6'd3, 1'b0, 6'd7, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        run_op(6'h00, 6'h01, 1'b0, 6'h3F, 1'b1, 1'b0, 1'b0);
        run_op(6'h20, 6'h01, 1'b0, 6'h1F, 1'b0, 1'b1, 1'b0);
        run_op(6'h1F, 6'h3F, 1'b0, 6'h20, 1'b1, 1'b1, 1'b0);
        run_op(6'd5,  6'd5,  1'b1, 6'h3F, 1'b1, 1'b0, 1'b0);
        run_op(6'd5,  6'd5,  1'b0, 6'h00, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        // Restart pulse mid-run must be ignored.
        run_op(6'd10, 6'd3, 1'b0, 6'd7, 1'b0, 1'b0, 1'b1);
        // Back-to-back: start asserted during the DONE cycle.
        run_op(6'h03, 6'h07, 1'b0, 6'h3C, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        chk("idle_after_done", 32'(busy), 32'd0);

        abort_op();
        run_op(6'h20, 6'h00, 1'b1, 6'h1F, 1'b0, 1'b1, 1'b0);
        @(negedge clk);

        // Random traffic checked by the model every cycle.
        for (int i = 0; i < 3000; i++) begin
            start_i = ($urandom_range(0, 2) == 0);
            a_i     = W'($urandom_range(0, 63));
            b_i     = W'($urandom_range(0, 63));
            bin_i   = 1'($urandom_range(0, 1));
            rst_i   = ($urandom_range(0, 299) == 0);
            @(negedge clk);
        end
        rst_i = 1'b0;
        start_i = 1'b0;
        repeat (10) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
